// File: rtl/draw_request_arbiter.sv
// Serialises clear/tail/head/apple draw requests into one drawer stream; issue is 1 cycle after a slot fills.
// Only one draw is outstanding at a time: the next ovld waits for idone; new requests wait in single-entry slots.
module draw_request_arbiter #(
  parameter int                         H_LOGIC_WIDTH  = 5,
  parameter int                         V_LOGIC_WIDTH  = 5,
  parameter logic [H_LOGIC_WIDTH-1:0]   H_LOGIC_MAX    = 5'd31,
  parameter logic [V_LOGIC_WIDTH-1:0]   V_LOGIC_MAX    = 5'd23,
  parameter int                         COLOR_ID_WIDTH = 8,
  parameter logic [COLOR_ID_WIDTH-1:0]  CLEAR_COLOR    = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       head_vld,
  input  logic [H_LOGIC_WIDTH-1:0]   head_x,
  input  logic [V_LOGIC_WIDTH-1:0]   head_y,
  input  logic [COLOR_ID_WIDTH-1:0]  head_color,
  input  logic                       tail_vld,
  input  logic [H_LOGIC_WIDTH-1:0]   tail_x,
  input  logic [V_LOGIC_WIDTH-1:0]   tail_y,
  input  logic [COLOR_ID_WIDTH-1:0]  tail_color,
  input  logic                       apple_vld,
  input  logic [H_LOGIC_WIDTH-1:0]   apple_x,
  input  logic [V_LOGIC_WIDTH-1:0]   apple_y,
  input  logic [COLOR_ID_WIDTH-1:0]  apple_color,
  output logic [H_LOGIC_WIDTH-1:0]   ox,
  output logic [V_LOGIC_WIDTH-1:0]   oy,
  output logic [COLOR_ID_WIDTH-1:0]  ocolor,
  output logic                       ovld,
  input  logic                       idone,
  output logic                       busy,
  output logic                       clr_done,
  output logic                       overflow
);

  typedef enum logic [1:0] {IDLE, PIX_WAIT, CLR_ISSUE, CLR_WAIT} state_t;

  state_t state, state_nxt;

  logic                       clr_pend, tail_pend, head_pend, apple_pend;
  logic [H_LOGIC_WIDTH-1:0]   tail_x_q, head_x_q, apple_x_q;
  logic [V_LOGIC_WIDTH-1:0]   tail_y_q, head_y_q, apple_y_q;
  logic [COLOR_ID_WIDTH-1:0]  tail_c_q, head_c_q, apple_c_q;
  logic [H_LOGIC_WIDTH-1:0]   sweep_x;
  logic [V_LOGIC_WIDTH-1:0]   sweep_y;

  logic                       take_clr, take_tail, take_head, take_apple;
  logic                       pix_issue, clr_issue, sweep_start, sweep_adv, sweep_end;
  logic                       sweep_last;
  logic [H_LOGIC_WIDTH-1:0]   win_x;
  logic [V_LOGIC_WIDTH-1:0]   win_y;
  logic [COLOR_ID_WIDTH-1:0]  win_c;

  assign sweep_last = (sweep_x == H_LOGIC_MAX) && (sweep_y == V_LOGIC_MAX);
  assign busy       = (state != IDLE) || clr_pend || tail_pend || head_pend || apple_pend;

  always_comb begin
    state_nxt   = state;
    take_clr    = 1'b0;
    take_tail   = 1'b0;
    take_head   = 1'b0;
    take_apple  = 1'b0;
    pix_issue   = 1'b0;
    clr_issue   = 1'b0;
    sweep_start = 1'b0;
    sweep_adv   = 1'b0;
    sweep_end   = 1'b0;
    win_x       = tail_x_q;
    win_y       = tail_y_q;
    win_c       = tail_c_q;
    case (state)
      IDLE: begin
        // clear outranks all pixel work; tail before head so an erase never lands on a fresh head
        if (clr_pend) begin
          take_clr    = 1'b1;
          sweep_start = 1'b1;
          state_nxt   = CLR_ISSUE;
        end else if (tail_pend) begin
          take_tail = 1'b1;
          pix_issue = 1'b1;
          state_nxt = PIX_WAIT;
        end else if (head_pend) begin
          take_head = 1'b1;
          pix_issue = 1'b1;
          win_x     = head_x_q;
          win_y     = head_y_q;
          win_c     = head_c_q;
          state_nxt = PIX_WAIT;
        end else if (apple_pend) begin
          take_apple = 1'b1;
          pix_issue  = 1'b1;
          win_x      = apple_x_q;
          win_y      = apple_y_q;
          win_c      = apple_c_q;
          state_nxt  = PIX_WAIT;
        end
      end
      PIX_WAIT: begin
        if (idone) state_nxt = IDLE;
      end
      CLR_ISSUE: begin
        clr_issue = 1'b1;
        state_nxt = CLR_WAIT;
      end
      CLR_WAIT: begin
        if (idone) begin
          if (sweep_last) begin
            sweep_end = 1'b1;
            state_nxt = IDLE;
          end else begin
            sweep_adv = 1'b1;
            state_nxt = CLR_ISSUE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ovld       <= 1'b0;
      clr_done   <= 1'b0;
      overflow   <= 1'b0;
      ox         <= '0;
      oy         <= '0;
      ocolor     <= '0;
      sweep_x    <= '0;
      sweep_y    <= '0;
      clr_pend   <= 1'b0;
      tail_pend  <= 1'b0;
      head_pend  <= 1'b0;
      apple_pend <= 1'b0;
      tail_x_q   <= '0;
      tail_y_q   <= '0;
      tail_c_q   <= '0;
      head_x_q   <= '0;
      head_y_q   <= '0;
      head_c_q   <= '0;
      apple_x_q  <= '0;
      apple_y_q  <= '0;
      apple_c_q  <= '0;
    end else begin
      state    <= state_nxt;
      ovld     <= pix_issue || clr_issue;
      clr_done <= sweep_end;

      if (pix_issue) begin
        ox     <= win_x;
        oy     <= win_y;
        ocolor <= win_c;
      end else if (clr_issue) begin
        ox     <= sweep_x;
        oy     <= sweep_y;
        ocolor <= CLEAR_COLOR;
      end

      // row-major sweep; wrap by compare so non power-of-two grids stay in range
      if (sweep_start) begin
        sweep_x <= '0;
        sweep_y <= '0;
      end else if (sweep_adv) begin
        if (sweep_x == H_LOGIC_MAX) begin
          sweep_x <= '0;
          sweep_y <= sweep_y + 1'b1;
        end else begin
          sweep_x <= sweep_x + 1'b1;
        end
      end

      if (clr)           clr_pend <= 1'b1;
      else if (take_clr) clr_pend <= 1'b0;

      if (tail_vld) begin
        tail_pend <= 1'b1;
        tail_x_q  <= tail_x;
        tail_y_q  <= tail_y;
        tail_c_q  <= tail_color;
      end else if (take_tail) begin
        tail_pend <= 1'b0;
      end

      if (head_vld) begin
        head_pend <= 1'b1;
        head_x_q  <= head_x;
        head_y_q  <= head_y;
        head_c_q  <= head_color;
      end else if (take_head) begin
        head_pend <= 1'b0;
      end

      if (apple_vld) begin
        apple_pend <= 1'b1;
        apple_x_q  <= apple_x;
        apple_y_q  <= apple_y;
        apple_c_q  <= apple_color;
      end else if (take_apple) begin
        apple_pend <= 1'b0;
      end

      if ((clr && clr_pend && !take_clr) || (tail_vld && tail_pend && !take_tail) ||
          (head_vld && head_pend && !take_head) || (apple_vld && apple_pend && !take_apple))
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_draw_request_arbiter.sv
// Directed bench for draw_request_arbiter: drawer model answers each ovld with idone, scoreboard checks issue order.
module tb_draw_request_arbiter;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [7:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst, clr;
  logic       head_vld, tail_vld, apple_vld;
  logic [4:0] head_x, head_y, tail_x, tail_y, apple_x, apple_y;
  logic [7:0] head_color, tail_color, apple_color;
  logic [4:0] ox, oy;
  logic [7:0] ocolor;
  logic       ovld, idone, busy, clr_done, overflow;
  logic       model_idone = 1'b0;
  logic       stray_idone = 1'b0;

  pix_t exp_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, ovld_cnt = 0, ovld_cyc = 0, clr_done_cnt = 0;
  int   dly = 5, cnt = 0;
  logic idone_smp = 1'b0, rst_smp = 1'b0, prev_ovld = 1'b0, outstanding = 1'b0;

  always #5 clk = ~clk;
  assign idone = model_idone | stray_idone;

  draw_request_arbiter dut (
    .clk(clk), .rst(rst), .clr(clr),
    .head_vld(head_vld), .head_x(head_x), .head_y(head_y), .head_color(head_color),
    .tail_vld(tail_vld), .tail_x(tail_x), .tail_y(tail_y), .tail_color(tail_color),
    .apple_vld(apple_vld), .apple_x(apple_x), .apple_y(apple_y), .apple_color(apple_color),
    .ox(ox), .oy(oy), .ocolor(ocolor), .ovld(ovld), .idone(idone),
    .busy(busy), .clr_done(clr_done), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    idone_smp = idone;
    rst_smp   = rst;
  end

  // drawer model and output monitor
  always @(negedge clk) begin
    pix_t e;
    if (rst_smp || idone_smp) outstanding = 1'b0;
    if (cnt > 0) begin
      cnt--;
      model_idone = (cnt == 0);
    end else begin
      model_idone = 1'b0;
    end
    if (ovld === 1'b1) begin
      chk("ovld_one_cycle", 32'(prev_ovld), 32'd0);
      chk("ovld_after_idone", 32'(outstanding), 32'd0);
      chk("ovld_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pix_xyc", 32'({ox, oy, ocolor}), 32'(e));
      end
      outstanding = 1'b1;
      ovld_cnt++;
      ovld_cyc = cyc;
      cnt = dly;
    end
    if (clr_done === 1'b1) begin
      clr_done_cnt++;
      chk("clr_done_last_xy", 32'({ox, oy}), 32'({5'd31, 5'd23}));
    end
    prev_ovld = ovld;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int target, input int budget, input string tag);
    int n = 0;
    while (ovld_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(ovld_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ovld"}, 32'(ovld), 32'd0);
    chk({tag, "_clr_done"}, 32'(clr_done), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ox"}, 32'(ox), 32'd0);
    chk({tag, "_oy"}, 32'(oy), 32'd0);
    chk({tag, "_ocolor"}, 32'(ocolor), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, base, n;
    rst = 1'b1; clr = 1'b0;
    head_vld = 1'b0; tail_vld = 1'b0; apple_vld = 1'b0;
    head_x = 5'd0; head_y = 5'd0; head_color = 8'h00;
    tail_x = 5'd0; tail_y = 5'd0; tail_color = 8'h00;
    apple_x = 5'd0; apple_y = 5'd0; apple_color = 8'h00;
    repeat (3) tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    // single head request
    exp_q.push_back({5'd3, 5'd4, 8'h0f});
    head_vld = 1'b1; head_x = 5'd3; head_y = 5'd4; head_color = 8'h0f;
    t0 = cyc;
    tick();
    head_vld = 1'b0;
    wait_cnt(1, 20, "single_issue");
    chk("single_latency", 32'(ovld_cyc - t0), 32'd2);
    chk("single_busy_wait", 32'(busy), 32'd1);
    n = 0;
    while (idone_smp !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("single_idone_seen", 32'(idone_smp), 32'd1);
    chk("single_busy_after", 32'(busy), 32'd0);
    chk("single_overflow", 32'(overflow), 32'd0);
    repeat (3) tick();

    // simultaneous tail/head/apple
    base = ovld_cnt;
    exp_q.push_back({5'd1, 5'd1, 8'hff});
    exp_q.push_back({5'd2, 5'd1, 8'h0f});
    exp_q.push_back({5'd9, 5'd9, 8'hf9});
    tail_vld = 1'b1;  tail_x = 5'd1;  tail_y = 5'd1;  tail_color = 8'hff;
    head_vld = 1'b1;  head_x = 5'd2;  head_y = 5'd1;  head_color = 8'h0f;
    apple_vld = 1'b1; apple_x = 5'd9; apple_y = 5'd9; apple_color = 8'hf9;
    tick();
    tail_vld = 1'b0; head_vld = 1'b0; apple_vld = 1'b0;
    wait_cnt(base + 3, 100, "simul_issue");
    wait_idle(50, "simul_idle");
    repeat (5) tick();
    chk("simul_count", 32'(ovld_cnt - base), 32'd3);
    chk("simul_sb_empty", 32'(exp_q.size()), 32'd0);

    // overwrite a pending head while the drawer is busy
    base = ovld_cnt;
    exp_q.push_back({5'd1, 5'd2, 8'h11});
    head_vld = 1'b1; head_x = 5'd1; head_y = 5'd2; head_color = 8'h11;
    tick();
    head_vld = 1'b0;
    wait_cnt(base + 1, 20, "ovw_first");
    head_vld = 1'b1; head_x = 5'd5; head_y = 5'd5; head_color = 8'h22;
    tick();
    head_x = 5'd6;
    tick();
    head_vld = 1'b0;
    exp_q.push_back({5'd6, 5'd5, 8'h22});
    chk("ovw_overflow", 32'(overflow), 32'd1);
    chk("ovw_still_waiting", 32'(ovld_cnt - base), 32'd1);
    wait_cnt(base + 2, 40, "ovw_second");
    wait_idle(50, "ovw_idle");
    repeat (5) tick();
    chk("ovw_count", 32'(ovld_cnt - base), 32'd2);

    // full clear with a head pending
    dly = 1;
    base = ovld_cnt;
    t0 = clr_done_cnt;
    for (int i = 0; i < 768; i++) exp_q.push_back({5'(i % 32), 5'(i / 32), 8'h00});
    exp_q.push_back({5'd7, 5'd7, 8'h33});
    clr = 1'b1;
    head_vld = 1'b1; head_x = 5'd7; head_y = 5'd7; head_color = 8'h33;
    tick();
    clr = 1'b0; head_vld = 1'b0;
    wait_cnt(base + 769, 6000, "clr_issue_all");
    wait_idle(50, "clr_idle");
    repeat (5) tick();
    chk("clr_count", 32'(ovld_cnt - base), 32'd769);
    chk("clr_done_pulses", 32'(clr_done_cnt - t0), 32'd1);
    chk("clr_sb_empty", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a sweep
    dly = 5;
    base = ovld_cnt;
    for (int i = 0; i < 100; i++) exp_q.push_back({5'(i % 32), 5'(i / 32), 8'h00});
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_cnt(base + 100, 1500, "rst_sweep_100");
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    repeat (40) tick();
    chk("midrst_no_ovld", 32'(ovld_cnt - base), 32'd100);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sb_empty", 32'(exp_q.size()), 32'd0);

    // stray idone while idle
    base = ovld_cnt;
    stray_idone = 1'b1;
    repeat (3) tick();
    stray_idone = 1'b0;
    repeat (5) tick();
    chk("stray_no_ovld", 32'(ovld_cnt - base), 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_ox_hold", 32'({ox, oy, ocolor}), 32'd0);

    // arbiter still serves requests normally afterwards
    exp_q.push_back({5'd4, 5'd6, 8'h44});
    apple_vld = 1'b1; apple_x = 5'd4; apple_y = 5'd6; apple_color = 8'h44;
    t0 = cyc;
    tick();
    apple_vld = 1'b0;
    wait_cnt(base + 1, 20, "post_issue");
    chk("post_latency", 32'(ovld_cyc - t0), 32'd2);
    wait_idle(50, "post_idle");
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
